// File: rtl/disp_stream_pkg.sv
// disp_stream_pkg: pixel record and framing defaults shared by the disparity stream producer and collector
package disp_stream_pkg;
    localparam int DEF_DECIMATE_FACTOR = 2;
    localparam int DEF_FRAME_W = 240;
    localparam int DEF_LINES_PER_BUF = 24;
    localparam int PIX_DISP_W = 8;
    localparam int PIX_CW = $clog2(DEF_DECIMATE_FACTOR + 1);
    typedef struct packed {
        logic [PIX_CW-1:0]     count;
        logic [7:0]            conf;
        logic [PIX_DISP_W-1:0] disp;
        logic                  sol;
        logic                  eol;
        logic                  eof;
    } pix_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with a registered read port and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_idx;
    logic pop, push, load;
    assign pop = rd_en && rd_valid;
    // the head already sits in rd_data, so a full FIFO can take a write into its slot while it pops
    assign push = wr_en && (count != LW'(DEPTH) || pop);
    assign rd_idx = rd_ptr + AW'(pop);
    assign load = pop ? count > LW'(1) : !rd_valid && count != '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_idx;
            count <= count + LW'(push) - LW'(pop);
            if (load) rd_data <= mem[rd_idx];
            rd_valid <= pop ? count > LW'(1) : rd_valid || count != '0;
        end
    end
endmodule

// File: rtl/disp_stream_collector.sv
// disp_stream_collector: sums decimated XOR bit groups into per-pixel counts, frames them
// and buffers them as a valid/ready pixel stream with almost-full back-pressure
module disp_stream_collector
    import disp_stream_pkg::*;
#(
    parameter int DECIMATE_FACTOR = DEF_DECIMATE_FACTOR,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int LINES_PER_BUF = DEF_LINES_PER_BUF,
    parameter int DISP_W = PIX_DISP_W,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN = 4,
    localparam int CW = $clog2(DECIMATE_FACTOR + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_stream_data,
    input  logic              pix_stream_valid,
    input  logic [7:0]        conf_in,
    input  logic [DISP_W-1:0] disp_in,
    output logic              fifo_almost_full,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_count,
    output logic [7:0]        out_conf,
    output logic [DISP_W-1:0] out_disp,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_eof,
    output logic              overflow
);
    localparam int BW = DECIMATE_FACTOR > 1 ? $clog2(DECIMATE_FACTOR) : 1;
    localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
    localparam int YW = LINES_PER_BUF > 1 ? $clog2(LINES_PER_BUF) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    if (AF_MARGIN < 2) begin : g_af_margin_check
        $error("AF_MARGIN must be at least 2 to absorb producer stall latency");
    end
    if (DISP_W != PIX_DISP_W || CW != PIX_CW) begin : g_pix_layout_check
        $error("DISP_W and DECIMATE_FACTOR must match the pix_t layout");
    end

    logic [BW-1:0] beat_idx;
    logic [CW-1:0] acc, sum;
    logic [XW-1:0] col;
    logic [YW-1:0] line;
    logic [LW-1:0] level, level_next;
    logic push, pop, drop, last_col, last_line;
    pix_t din, dout;

    assign sum = (beat_idx == '0 ? '0 : acc) + CW'(pix_stream_data);
    assign push = pix_stream_valid && beat_idx == BW'(DECIMATE_FACTOR - 1);
    assign last_col = col == XW'(FRAME_W - 1);
    assign last_line = line == YW'(LINES_PER_BUF - 1);
    assign din = '{count: sum, conf: conf_in, disp: disp_in,
                   sol: col == '0, eol: last_col, eof: last_col && last_line};
    assign pop = out_valid && out_ready;
    assign drop = push && level == LW'(FIFO_DEPTH) && !pop;
    assign level_next = level + LW'(push && !drop) - LW'(pop);

    // position advances even on a dropped pixel so framing stays aligned with the producer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_idx <= '0;
            acc <= '0;
            col <= '0;
            line <= '0;
            fifo_almost_full <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pix_stream_valid) begin
                beat_idx <= push ? '0 : beat_idx + 1'b1;
                acc <= sum;
            end
            if (push) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) line <= last_line ? '0 : line + 1'b1;
            end
            fifo_almost_full <= level_next >= LW'(FIFO_DEPTH - AF_MARGIN);
            overflow <= overflow | drop;
        end
    end

    sync_fifo #(.WIDTH($bits(pix_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(push),
        .wr_data(din),
        .rd_en(out_ready),
        .rd_data(dout),
        .rd_valid(out_valid),
        .count(level)
    );

    assign out_count = dout.count;
    assign out_conf = dout.conf;
    assign out_disp = dout.disp;
    assign out_sol = dout.sol;
    assign out_eol = dout.eol;
    assign out_eof = dout.eof;
endmodule
